keccak_pi_slice_engine: RTL and testbench

// - Applies the Keccak pi step to one 25-bit state slice (a 5x5 bit plane).
// - The host presents the 64 slices of a 1600-bit state one at a time.
// - Single unit built from a controller FSM and a datapath.
// - The datapath sweeps (x,y) counters and computes the destination index with a mod-5 ALU.
// - The result is a permuted slice, published atomically.

---
 rtl/keccak_pi_pkg.sv | 33 +++
 rtl/pi_mod5_alu.sv | 57 +++++
 rtl/keccak_pi_slice_engine.sv | 164 ++++++++++++++++
 tb/tb_keccak_pi_slice_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/keccak_pi_pkg.sv
// Shared definitions for the Keccak pi slice engine: geometry, controller
// state encoding and the (x,y) -> bit position helper.
package keccak_pi_pkg;

    localparam int DIM    = 5;
    localparam int LINE_W = DIM * DIM;
    localparam int IDX_W  = 6;

    // x/y sweep counters, mod-5 accumulator and bit-position widths
    localparam int CNT_W  = 3;
    localparam int ACC_W  = 5;
    localparam int POS_W  = 5;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIM - 1);
    localparam logic [ACC_W-1:0] MOD_K   = ACC_W'(DIM);
    localparam logic [ACC_W-1:0] MOD_K2  = ACC_W'(2 * DIM);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CALC   = 3'd2,
        ST_REDUCE = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } pi_state_e;

    // Bit position of lane (x,y) inside a slice: 5*y + x
    function automatic logic [POS_W-1:0] idx(input logic [CNT_W-1:0] x,
                                             input logic [CNT_W-1:0] y);
        return POS_W'(y) * POS_W'(DIM) + POS_W'(x);
    endfunction

endpackage

// File: rtl/pi_mod5_alu.sv
// Mod-5 ALU for the pi destination row: loads 2x+3y and then reduces it by
// repeated subtraction of 5, one subtraction per cycle.
//
// Flags are look-ahead so the controller never spends a cycle just to find
// out that the residue is already below 5:
//   sum_ge5 - the value about to be loaded (2x+3y) still needs reducing
//   rem_ge5 - after this cycle's subtraction the accumulator is still >= 5
module pi_mod5_alu
    import keccak_pi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             calc,
    input  logic             reduce,
    input  logic [CNT_W-1:0] x,
    input  logic [CNT_W-1:0] y,
    output logic [ACC_W-1:0] acc,
    output logic             sum_ge5,
    output logic             rem_ge5
);

    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Raw destination row 2x+3y (max 20, fits 5 bits unsigned) and flags
    always_comb begin
        sum     = (ACC_W'(x) << 1) + (ACC_W'(y) << 1) + ACC_W'(y);
        sum_ge5 = (sum >= MOD_K);
        rem_ge5 = (acc_q >= MOD_K2);
    end

    // Accumulator next value: clear, load 2x+3y, or subtract 5 while >= 5
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (calc) begin
            acc_d = sum;
        end else if (reduce && (acc_q >= MOD_K)) begin
            acc_d = acc_q - MOD_K;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/keccak_pi_slice_engine.sv
// Keccak pi step on one 25-bit slice. The controller sweeps (x,y) over the
// 5x5 plane; for each lane the mod-5 ALU produces Y = (2x+3y) mod 5 and the
// source bit is written to destination (X,Y) = (y,Y) of a private buffer.
// The finished slice and its index tag are published together in one edge,
// so mem_out/out_idx never expose a partially permuted slice.
//
// Interface: start is a level sampled only in IDLE. While busy, start,
// line_in and line_idx are ignored; the copy captured in LOAD is used.
// done pulses for exactly one cycle, the cycle in which the new mem_out and
// out_idx are first visible; both then hold until the next done.
module keccak_pi_slice_engine
    import keccak_pi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LINE_W-1:0] line_in,
    input  logic [IDX_W-1:0]  line_idx,
    output logic [LINE_W-1:0] mem_out,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    pi_state_e         state_q, state_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic [LINE_W-1:0] src_q, src_d;
    logic [LINE_W-1:0] dst_q, dst_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] mem_out_q, mem_out_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;

    logic              alu_clr;
    logic              alu_calc;
    logic              alu_reduce;
    logic [ACC_W-1:0]  alu_acc;
    logic              alu_sum_ge5;
    logic              alu_rem_ge5;

    logic              last_cell;
    logic [POS_W-1:0]  wr_pos;

    pi_mod5_alu u_alu (
        .clk     (clk),
        .rst     (rst),
        .clr     (alu_clr),
        .calc    (alu_calc),
        .reduce  (alu_reduce),
        .x       (x_q),
        .y       (y_q),
        .acc     (alu_acc),
        .sum_ge5 (alu_sum_ge5),
        .rem_ge5 (alu_rem_ge5)
    );

    // Controller next-state and datapath next values
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        src_d      = src_q;
        dst_d      = dst_q;
        idx_d      = idx_q;
        mem_out_d  = mem_out_q;
        out_idx_d  = out_idx_q;
        alu_clr    = 1'b0;
        alu_calc   = 1'b0;
        alu_reduce = 1'b0;
        wr_pos     = '0;
        last_cell  = (x_q == CNT_MAX) && (y_q == CNT_MAX);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                src_d   = line_in;
                idx_d   = line_idx;
                dst_d   = '0;
                x_d     = '0;
                y_d     = '0;
                alu_clr = 1'b1;
                state_d = ST_CALC;
            end

            // A row value already below 5 skips REDUCE entirely, so each
            // lane costs 2 cycles plus one per subtraction.
            ST_CALC: begin
                alu_calc = 1'b1;
                state_d  = alu_sum_ge5 ? ST_REDUCE : ST_WRITE;
            end

            ST_REDUCE: begin
                alu_reduce = 1'b1;
                state_d    = alu_rem_ge5 ? ST_REDUCE : ST_WRITE;
            end

            // Destination lane (X,Y) = (y, acc) lives at bit 5*acc + y
            ST_WRITE: begin
                wr_pos        = POS_W'(alu_acc) * POS_W'(DIM) + POS_W'(y_q);
                dst_d[wr_pos] = src_q[idx(x_q, y_q)];
                if (x_q == CNT_MAX) begin
                    x_d = '0;
                    y_d = (y_q == CNT_MAX) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
                if (last_cell) begin
                    // Publish on the edge into DONE so done and the new
                    // result appear in the same cycle.
                    mem_out_d = dst_d;
                    out_idx_d = idx_q;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_CALC;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, buffers and published result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            idx_q     <= '0;
            mem_out_q <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            idx_q     <= idx_d;
            mem_out_q <= mem_out_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign mem_out   = mem_out_q;
    assign out_idx   = out_idx_q;
    assign busy      = (state_q == ST_LOAD)   || (state_q == ST_CALC) ||
                       (state_q == ST_REDUCE) || (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keccak_pi_slice_engine.sv
// Bench for keccak_pi_slice_engine: a driver issues slices (directed, random,
// back-to-back) and pushes the expected result; a monitor pops and compares
// whenever done is seen.
module tb_keccak_pi_slice_engine;
    import keccak_pi_pkg::*;

    localparam int LAT_EDGES = 91;   // done in the 92nd cycle after the sampling edge
    localparam int N_RANDOM  = 250;
    localparam int N_B2B     = 64;
    localparam int EW        = IDX_W + LINE_W;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [LINE_W-1:0] line_in = '0;
    logic [IDX_W-1:0]  line_idx = '0;
    logic [LINE_W-1:0] mem_out;
    logic [IDX_W-1:0]  out_idx;
    logic              busy;
    logic              done;
    logic [2:0]        dbg_state;

    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keccak_pi_slice_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .line_in   (line_in),
        .line_idx  (line_idx),
        .mem_out   (mem_out),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [EW-1:0] exp_q[$];
    int          exp_cyc_q[$];
    int          exp_pop_q[$];

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference pi: source lane (x,y) moves to (X,Y) = (y, (2x+3y) mod 5)
    function automatic logic [LINE_W-1:0] pi_ref(input logic [LINE_W-1:0] a);
        logic [LINE_W-1:0] r;
        r = '0;
        for (int y = 0; y < DIM; y++)
            for (int x = 0; x < DIM; x++)
                r[5 * ((2 * x + 3 * y) % 5) + y] = a[5 * y + x];
        return r;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge while the DUT is idle; returns at the negedge of
    // the next idle cycle. Inputs are scrambled once captured.
    task automatic issue(input logic [LINE_W-1:0] line, input logic [IDX_W-1:0] id,
                         input logic [LINE_W-1:0] exp_mem, input bit hold);
        line_in  = line;
        line_idx = id;
        start    = 1'b1;
        @(negedge clk);
        exp_q.push_back({id, exp_mem});
        exp_cyc_q.push_back(cyc + LAT_EDGES);
        exp_pop_q.push_back($countones(line));
        @(negedge clk);
        line_in  = LINE_W'($urandom);
        line_idx = IDX_W'($urandom);
        start    = hold;
        repeat (91) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    logic [EW-1:0] mon_e;
    int            mon_c;
    int            mon_p;
    logic          prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst && done) begin
            chk(!prev_done, "done_single_cycle", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                mon_p = exp_pop_q.pop_front();
                chk(mem_out == mon_e[LINE_W-1:0], "mem_out",
                    32'(mem_out), 32'(mon_e[LINE_W-1:0]));
                chk(out_idx == mon_e[EW-1:LINE_W], "out_idx",
                    32'(out_idx), 32'(mon_e[EW-1:LINE_W]));
                chk(cyc == mon_c, "done_latency", 32'(cyc), 32'(mon_c));
                chk($countones(mem_out) == mon_p, "popcount",
                    32'($countones(mem_out)), 32'(mon_p));
            end
        end
        prev_done = rst && done;
    end

    // ---------------- stimulus ----------------
    logic [LINE_W-1:0] rnd;
    bit                done_seen;
    int                drain;

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk(mem_out == '0, "reset_mem_out", 32'(mem_out), 32'd0);
        chk(out_idx == '0, "reset_out_idx", 32'(out_idx), 32'd0);
        chk(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
        chk(done == 1'b0, "reset_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed lanes and the fixed-point patterns
        issue(25'h0000002, 6'd3,  25'h0000400, 1'b0);
        issue(25'h0000020, 6'd7,  25'h0010000, 1'b0);
        issue(25'h1000000, 6'd12, 25'h0000010, 1'b0);
        issue(25'h1FFFFFF, 6'd33, 25'h1FFFFFF, 1'b0);
        issue(25'h0000000, 6'd63, 25'h0000000, 1'b0);

        // Random slices against the reference model
        for (int i = 0; i < N_RANDOM; i++) begin
            rnd = LINE_W'($urandom);
            issue(rnd, IDX_W'(i), pi_ref(rnd), 1'b0);
        end

        // Abort in the middle of a REDUCE run (cycle 40 of the slice)
        line_in  = 25'h1555555;
        line_idx = 6'd42;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (39) @(negedge clk);
        chk(busy == 1'b1, "busy_mid_slice", 32'(busy), 32'd1);
        chk(dbg_state == 3'(ST_REDUCE), "state_at_cycle40", 32'(dbg_state), 32'(ST_REDUCE));
        rst = 1'b0;
        #1;
        chk(busy == 1'b0, "abort_busy", 32'(busy), 32'd0);
        chk(mem_out == '0, "abort_mem_out", 32'(mem_out), 32'd0);
        chk(out_idx == '0, "abort_out_idx", 32'(out_idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        chk(!done_seen, "no_done_after_abort", 32'(done_seen), 32'd0);
        chk(mem_out == '0, "mem_out_held_after_abort", 32'(mem_out), 32'd0);

        // Normal operation after the abort
        rnd = LINE_W'($urandom);
        issue(rnd, 6'd21, pi_ref(rnd), 1'b0);

        // Back-to-back with start held high
        for (int i = 0; i < N_B2B; i++) begin
            rnd = LINE_W'($urandom);
            issue(rnd, IDX_W'(i), pi_ref(rnd), 1'b1);
        end
        start = 1'b0;

        // Let the monitor drain, bounded
        drain = 0;
        while (exp_q.size() != 0 && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        chk(exp_q.size() == 0, "drain_outstanding", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
